// File: rtl/e203_exu_muldiv_arb.sv
// -----------------------------------------------------------------------------
// e203_exu_muldiv_arb
//
// Two-requester arbiter and sequencer in front of the shared multi-cycle
// MUL/DIV unit. Requester 0 is the ALU issue path and requester 1 is the
// co-processor / long-pipe path. One operation is in flight at a time. The
// grant is round-robin when both requesters ask together. The accepted
// operation is launched to the unit, and its result is returned to the owner.
// A pipeline flush kills the operation in flight. If the unit still owes a
// result, that result is accepted later and thrown away.
//
// Optional feature (macro E203_MULDIV_ARB_WDT_EN):
//   A watchdog limits how long the block waits for the unit. After WDT_CYCLES
//   WAIT cycles the owner gets a response with rsp_err=1 and wdat=0. The late
//   result that arrives afterwards is accepted and discarded. Without the
//   macro, rsp_err is tied to 0 and WAIT lasts until the unit answers.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rX_valid / rX_ready      request handshake of requester X (X = 0, 1)
//   rX_rs1, rX_rs2, rX_op    operands and op code (0..7 = MUL..REMU)
//   rX_itag                  instruction tag, echoed on the response
//   rX_rsp_valid / _ready    response handshake of requester X
//   rX_rsp_wdat, _itag, _err response data, echoed tag, watchdog error
//   m_valid / m_ready        launch handshake towards the MUL/DIV unit
//   m_rs1, m_rs2, m_op, m_itag  launched operation
//   m_rsp_valid / m_rsp_ready   result handshake from the MUL/DIV unit
//   m_rsp_wdat               unit result data
//   flush_pulse              one-cycle pipeline flush
//   busy                     high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module e203_exu_muldiv_arb #(
    parameter int XLEN       = 32,
    parameter int ITAG_W     = 1,
    parameter int WDT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [XLEN-1:0]   r0_rs1,
    input  logic [XLEN-1:0]   r0_rs2,
    input  logic [2:0]        r0_op,
    input  logic [ITAG_W-1:0] r0_itag,
    output logic              r0_rsp_valid,
    input  logic              r0_rsp_ready,
    output logic [XLEN-1:0]   r0_rsp_wdat,
    output logic [ITAG_W-1:0] r0_rsp_itag,
    output logic              r0_rsp_err,

    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [XLEN-1:0]   r1_rs1,
    input  logic [XLEN-1:0]   r1_rs2,
    input  logic [2:0]        r1_op,
    input  logic [ITAG_W-1:0] r1_itag,
    output logic              r1_rsp_valid,
    input  logic              r1_rsp_ready,
    output logic [XLEN-1:0]   r1_rsp_wdat,
    output logic [ITAG_W-1:0] r1_rsp_itag,
    output logic              r1_rsp_err,

    output logic              m_valid,
    input  logic              m_ready,
    output logic [XLEN-1:0]   m_rs1,
    output logic [XLEN-1:0]   m_rs2,
    output logic [2:0]        m_op,
    output logic [ITAG_W-1:0] m_itag,
    input  logic              m_rsp_valid,
    output logic              m_rsp_ready,
    input  logic [XLEN-1:0]   m_rsp_wdat,

    input  logic              flush_pulse,
    output logic              busy
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_DRAIN = 3'd4
    } state_e;

    state_e              state_r;
    state_e              state_nxt_s;
    logic                last_grant_r;
    logic                owner_r;
    logic [XLEN-1:0]     rs1_r;
    logic [XLEN-1:0]     rs2_r;
    logic [2:0]          op_r;
    logic [ITAG_W-1:0]   itag_r;
    logic [XLEN-1:0]     wdat_r;

    logic                grant_s;
    logic                accept_s;
    logic                owner_rsp_ready_s;
    logic                late_drain_s;
    logic                wdt_fire_s;
    logic                err_s;
    logic                real_rsp_s;

    // The watchdog limit must be positive in every build.
    if (WDT_CYCLES < 1) begin : g_wdt_cfg_chk
        $error("WDT_CYCLES must be at least 1");
    end

    // Round-robin pick: on contention the requester not granted last time wins.
    always_comb begin
        if (r0_valid && r1_valid) begin
            grant_s = ~last_grant_r;
        end else if (r1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // A flush in the same cycle blocks acceptance. Reset masks it as well.
    assign accept_s = ~rst & (state_r == ST_IDLE) & ~flush_pulse & (r0_valid | r1_valid);

    assign owner_rsp_ready_s = owner_r ? r1_rsp_ready : r0_rsp_ready;

    // A unit result that is not an orphan left over from a watchdog timeout.
    assign real_rsp_s = m_rsp_valid & ~late_drain_s;

`ifdef E203_MULDIV_ARB_WDT_EN
    localparam int WDT_W = $clog2(WDT_CYCLES + 1);

    logic [WDT_W-1:0] wdt_cnt_r;
    logic             late_drain_r;
    logic             err_r;

    assign late_drain_s = late_drain_r;
    assign err_s        = err_r;
    assign wdt_fire_s   = (state_r == ST_WAIT) & ~flush_pulse & ~real_rsp_s &
                          (wdt_cnt_r == WDT_W'(WDT_CYCLES - 1));

    // Watchdog counter and the flag that swallows the orphaned late result.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdt_cnt_r    <= '0;
            late_drain_r <= 1'b0;
        end else begin
            if (state_r == ST_ISSUE) begin
                wdt_cnt_r <= '0;
            end else if (state_r == ST_WAIT) begin
                wdt_cnt_r <= wdt_cnt_r + WDT_W'(1);
            end
            if (wdt_fire_s) begin
                late_drain_r <= 1'b1;
            end else if (late_drain_r && m_rsp_valid) begin
                late_drain_r <= 1'b0;
            end
        end
    end
`else
    assign late_drain_s = 1'b0;
    assign wdt_fire_s   = 1'b0;
    assign err_s        = 1'b0;
`endif

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic. Flush has priority over every other event.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (flush_pulse) begin
                    state_nxt_s = ST_IDLE;
                end else if (m_ready) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (flush_pulse) begin
                    // Result already here: drop it. Otherwise it is still owed.
                    if (real_rsp_s) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DRAIN;
                    end
                end else if (real_rsp_s || wdt_fire_s) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (flush_pulse || owner_rsp_ready_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            ST_DRAIN: begin
                if (real_rsp_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

`ifdef E203_MULDIV_ARB_WDT_EN
    // Response error flag: set by a watchdog timeout, cleared by a real result.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (wdt_fire_s) begin
            err_r <= 1'b1;
        end else if ((state_r == ST_WAIT) && real_rsp_s && !flush_pulse) begin
            err_r <= 1'b0;
        end
    end
`endif

    // Operation latch on acceptance and result latch at the end of WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r <= 1'b1;
            owner_r      <= 1'b0;
            rs1_r        <= '0;
            rs2_r        <= '0;
            op_r         <= 3'd0;
            itag_r       <= '0;
            wdat_r       <= '0;
        end else begin
            if (accept_s) begin
                last_grant_r <= grant_s;
                owner_r      <= grant_s;
                rs1_r        <= grant_s ? r1_rs1  : r0_rs1;
                rs2_r        <= grant_s ? r1_rs2  : r0_rs2;
                op_r         <= grant_s ? r1_op   : r0_op;
                itag_r       <= grant_s ? r1_itag : r0_itag;
            end
            if ((state_r == ST_WAIT) && real_rsp_s && !flush_pulse) begin
                wdat_r <= m_rsp_wdat;
            end else if (wdt_fire_s) begin
                wdat_r <= '0;
            end
        end
    end

    assign r0_ready     = accept_s & ~grant_s;
    assign r1_ready     = accept_s &  grant_s;

    assign m_valid      = (state_r == ST_ISSUE) & ~flush_pulse & ~rst;
    assign m_rs1        = rs1_r;
    assign m_rs2        = rs2_r;
    assign m_op         = op_r;
    assign m_itag       = itag_r;
    assign m_rsp_ready  = ((state_r == ST_WAIT) | (state_r == ST_DRAIN) | late_drain_s) & ~rst;

    assign r0_rsp_valid = (state_r == ST_RESP) & ~owner_r;
    assign r1_rsp_valid = (state_r == ST_RESP) &  owner_r;
    assign r0_rsp_wdat  = r0_rsp_valid ? wdat_r : '0;
    assign r1_rsp_wdat  = r1_rsp_valid ? wdat_r : '0;
    assign r0_rsp_itag  = r0_rsp_valid ? itag_r : '0;
    assign r1_rsp_itag  = r1_rsp_valid ? itag_r : '0;
    assign r0_rsp_err   = r0_rsp_valid & err_s;
    assign r1_rsp_err   = r1_rsp_valid & err_s;

    assign busy         = (state_r != ST_IDLE);

endmodule

// File: tb/tb_e203_exu_muldiv_arb.sv
// -----------------------------------------------------------------------------
// Testbench for e203_exu_muldiv_arb. It has directed scenarios for reset,
// single operations, contention, backpressure, flushes and reset during an
// operation, followed by randomized transactions. A behavioural model holds
// the round-robin winner and the RISC-V MUL/DIV results that the bench's
// stand-in unit returns.
// -----------------------------------------------------------------------------
module tb_e203_exu_muldiv_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_valid, r0_ready, r0_rsp_valid, r0_rsp_ready, r0_rsp_err;
    logic [31:0] r0_rs1, r0_rs2, r0_rsp_wdat;
    logic [2:0]  r0_op;
    logic [0:0]  r0_itag, r0_rsp_itag;
    logic        r1_valid, r1_ready, r1_rsp_valid, r1_rsp_ready, r1_rsp_err;
    logic [31:0] r1_rs1, r1_rs2, r1_rsp_wdat;
    logic [2:0]  r1_op;
    logic [0:0]  r1_itag, r1_rsp_itag;
    logic        m_valid, m_ready, m_rsp_valid, m_rsp_ready;
    logic [31:0] m_rs1, m_rs2, m_rsp_wdat;
    logic [2:0]  m_op;
    logic [0:0]  m_itag;
    logic        flush_pulse, busy;

    always #5 clk = ~clk;

    e203_exu_muldiv_arb dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_rs1(r0_rs1), .r0_rs2(r0_rs2),
        .r0_op(r0_op), .r0_itag(r0_itag), .r0_rsp_valid(r0_rsp_valid),
        .r0_rsp_ready(r0_rsp_ready), .r0_rsp_wdat(r0_rsp_wdat),
        .r0_rsp_itag(r0_rsp_itag), .r0_rsp_err(r0_rsp_err),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_rs1(r1_rs1), .r1_rs2(r1_rs2),
        .r1_op(r1_op), .r1_itag(r1_itag), .r1_rsp_valid(r1_rsp_valid),
        .r1_rsp_ready(r1_rsp_ready), .r1_rsp_wdat(r1_rsp_wdat),
        .r1_rsp_itag(r1_rsp_itag), .r1_rsp_err(r1_rsp_err),
        .m_valid(m_valid), .m_ready(m_ready), .m_rs1(m_rs1), .m_rs2(m_rs2),
        .m_op(m_op), .m_itag(m_itag), .m_rsp_valid(m_rsp_valid),
        .m_rsp_ready(m_rsp_ready), .m_rsp_wdat(m_rsp_wdat),
        .flush_pulse(flush_pulse), .busy(busy)
    );

    int          checks = 0;
    int          errors = 0;
    int          last_win = 1;       // model: requester granted most recently
    logic [31:0] exp_rs1, exp_rs2;
    logic [2:0]  exp_op;
    logic        exp_itag;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference MUL/DIV results, following RISC-V M-extension semantics.
    function automatic logic [31:0] muldiv(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return $signed(a) / $signed(b);
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic logic own_valid(input int w);
        return (w == 1) ? r1_rsp_valid : r0_rsp_valid;
    endfunction

    task automatic accept_phase(input logic v0, input logic v1,
                                input logic [2:0] op0, input logic [2:0] op1,
                                input logic [31:0] a0, input logic [31:0] b0,
                                input logic [31:0] a1, input logic [31:0] b1,
                                input logic t0, input logic t1, output int win);
        if (v0 && v1) win = 1 - last_win;
        else if (v1)  win = 1;
        else          win = 0;
        r0_valid = v0; r0_op = op0; r0_rs1 = a0; r0_rs2 = b0; r0_itag = t0;
        r1_valid = v1; r1_op = op1; r1_rs1 = a1; r1_rs2 = b1; r1_itag = t1;
        #1;
        chk("r0_ready_grant", r0_ready, win == 0);
        chk("r1_ready_grant", r1_ready, win == 1);
        exp_rs1  = (win == 1) ? a1 : a0;
        exp_rs2  = (win == 1) ? b1 : b0;
        exp_op   = (win == 1) ? op1 : op0;
        exp_itag = (win == 1) ? t1 : t0;
        step();
        last_win = win;
        r0_valid = 1'b0; r1_valid = 1'b0;
        r0_rs1 = $urandom; r1_rs1 = $urandom; r0_op = 3'($urandom); r1_itag = 1'($urandom);
    endtask

    task automatic launch_phase(input int stall);
        for (int i = 0; i <= stall; i++) begin
            m_ready = (i == stall);
            #1;
            chk("m_valid_issue", m_valid, 1'b1);
            chk("m_rs1", m_rs1, exp_rs1);
            chk("m_rs2", m_rs2, exp_rs2);
            chk("m_op", m_op, exp_op);
            chk("m_itag", m_itag, exp_itag);
            step();
        end
        m_ready = 1'b0;
        #1;
        chk("m_valid_after_launch", m_valid, 1'b0);
        chk("m_rsp_ready_wait", m_rsp_ready, 1'b1);
    endtask

    task automatic unit_phase(input int lat, input logic [31:0] res);
        for (int i = 0; i < lat; i++) begin
            chk("rsp_quiet_wait", {r1_rsp_valid, r0_rsp_valid}, 2'b00);
            step();
        end
        m_rsp_valid = 1'b1; m_rsp_wdat = res;
        #1;
        chk("m_rsp_ready_take", m_rsp_ready, 1'b1);
        step();
        m_rsp_valid = 1'b0; m_rsp_wdat = $urandom;
    endtask

    task automatic resp_phase(input int win, input int stall, input logic [31:0] res,
                              input logic itag, input logic err);
        for (int i = 0; i <= stall; i++) begin
            if (win == 1) begin
                r1_rsp_ready = (i == stall); r0_rsp_ready = 1'($urandom);
            end else begin
                r0_rsp_ready = (i == stall); r1_rsp_ready = 1'($urandom);
            end
            #1;
            chk("own_rsp_valid", own_valid(win), 1'b1);
            chk("other_rsp_valid", own_valid(1 - win), 1'b0);
            chk("rsp_wdat", (win == 1) ? r1_rsp_wdat : r0_rsp_wdat, res);
            chk("rsp_itag", (win == 1) ? r1_rsp_itag : r0_rsp_itag, itag);
            chk("rsp_err", (win == 1) ? r1_rsp_err : r0_rsp_err, err);
            chk("m_rsp_ready_resp", m_rsp_ready, 1'b0);
            step();
        end
        r0_rsp_ready = 1'b0; r1_rsp_ready = 1'b0;
        #1;
        chk("busy_after_resp", busy, 1'b0);
        chk("rsp_gone", {r1_rsp_valid, r0_rsp_valid}, 2'b00);
    endtask

    task automatic run_txn(input logic v0, input logic v1,
                           input logic [2:0] op0, input logic [2:0] op1,
                           input logic [31:0] a0, input logic [31:0] b0,
                           input logic [31:0] a1, input logic [31:0] b1,
                           input logic t0, input logic t1,
                           input int ls, input int lat, input int rs);
        int          win;
        logic [31:0] res;
        accept_phase(v0, v1, op0, op1, a0, b0, a1, b1, t0, t1, win);
        launch_phase(ls);
        res = muldiv(exp_op, exp_rs1, exp_rs2);
        unit_phase(lat, res);
        resp_phase(win, rs, res, exp_itag, 1'b0);
    endtask

    initial begin
        int          win;
        logic        v0, v1;
        logic [31:0] res;

        // Reset with active-looking inputs: every output must stay quiet.
        rst = 1'b1; flush_pulse = 1'b0;
        r0_valid = 1'b1; r1_valid = 1'b1; m_rsp_valid = 1'b1; m_ready = 1'b1;
        r0_rsp_ready = 1'b0; r1_rsp_ready = 1'b0;
        r0_rs1 = 32'd0; r0_rs2 = 32'd0; r0_op = 3'd0; r0_itag = 1'b0;
        r1_rs1 = 32'd0; r1_rs2 = 32'd0; r1_op = 3'd0; r1_itag = 1'b0;
        m_rsp_wdat = 32'd0;
        step(); step();
        chk("rst_r0_ready", r0_ready, 1'b0);
        chk("rst_r1_ready", r1_ready, 1'b0);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_rsp_ready", m_rsp_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rsp_valid", {r1_rsp_valid, r0_rsp_valid}, 2'b00);
        chk("rst_m_rs1", m_rs1, 32'd0);
        chk("rst_rsp_err", {r1_rsp_err, r0_rsp_err}, 2'b00);
        rst = 1'b0; r0_valid = 1'b0; r1_valid = 1'b0; m_rsp_valid = 1'b0; m_ready = 1'b0;
        step();
        chk("idle_busy", busy, 1'b0);
        chk("idle_m_valid", m_valid, 1'b0);

        // Contention from reset: grants must alternate 0,1,0,1.
        for (int i = 0; i < 4; i++) begin
            run_txn(1'b1, 1'b1, 3'd0, 3'd3, 32'(i + 2), 32'd9, 32'hFFFF_0000, 32'(i + 7),
                    1'b0, 1'b1, 0, 2, 0);
        end

        // Single op: MUL 3*5, unit answers on its 17th WAIT cycle.
        run_txn(1'b1, 1'b0, 3'd0, 3'd0, 32'd3, 32'd5, 32'd0, 32'd0, 1'b1, 1'b0, 0, 16, 0);

        // Backpressure: launch stalled 3 cycles, response stalled 4 cycles.
        run_txn(1'b1, 1'b0, 3'd1, 3'd0, 32'h8000_0001, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 3, 2, 4);

        // Flush in WAIT: DIV 100/7 drained silently.
        accept_phase(1'b1, 1'b0, 3'd4, 3'd0, 32'd100, 32'd7, 32'd0, 32'd0, 1'b1, 1'b0, win);
        launch_phase(0);
        for (int i = 0; i < 4; i++) step();
        flush_pulse = 1'b1;
        step();
        flush_pulse = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("drain_busy", busy, 1'b1);
            chk("drain_m_rsp_ready", m_rsp_ready, 1'b1);
            chk("drain_rsp_quiet", {r1_rsp_valid, r0_rsp_valid}, 2'b00);
            step();
        end
        m_rsp_valid = 1'b1; m_rsp_wdat = 32'd14;
        step();
        m_rsp_valid = 1'b0;
        #1;
        chk("drain_busy_drop", busy, 1'b0);
        chk("drain_no_rsp", {r1_rsp_valid, r0_rsp_valid}, 2'b00);
        step();
        chk("drain_no_rsp_late", {r1_rsp_valid, r0_rsp_valid}, 2'b00);

        // Flush and request together in IDLE: refused, accepted next cycle.
        r1_valid = 1'b1; flush_pulse = 1'b1;
        #1;
        chk("flush_idle_r1_ready", r1_ready, 1'b0);
        chk("flush_idle_r0_ready", r0_ready, 1'b0);
        step();
        flush_pulse = 1'b0;
        chk("flush_idle_busy", busy, 1'b0);
        run_txn(1'b0, 1'b1, 3'd0, 3'd5, 32'd0, 32'd0, 32'd1000, 32'd33, 1'b0, 1'b1, 1, 3, 1);

        // Flush in ISSUE: no launch, back to IDLE.
        accept_phase(1'b1, 1'b0, 3'd2, 3'd0, 32'd11, 32'd12, 32'd0, 32'd0, 1'b0, 1'b0, win);
        flush_pulse = 1'b1; m_ready = 1'b1;
        #1;
        chk("flush_issue_m_valid", m_valid, 1'b0);
        step();
        flush_pulse = 1'b0; m_ready = 1'b0;
        #1;
        chk("flush_issue_busy", busy, 1'b0);
        chk("flush_issue_m_rsp_ready", m_rsp_ready, 1'b0);

        // Flush in RESP: the response is dropped.
        accept_phase(1'b0, 1'b1, 3'd0, 3'd0, 32'd0, 32'd0, 32'd6, 32'd7, 1'b0, 1'b0, win);
        launch_phase(0);
        unit_phase(1, 32'd42);
        chk("flush_resp_pre_valid", r1_rsp_valid, 1'b1);
        flush_pulse = 1'b1;
        step();
        flush_pulse = 1'b0;
        #1;
        chk("flush_resp_busy", busy, 1'b0);
        chk("flush_resp_rsp", {r1_rsp_valid, r0_rsp_valid}, 2'b00);

        // Flush in WAIT while the result arrives: result discarded, IDLE.
        accept_phase(1'b1, 1'b0, 3'd6, 3'd0, 32'd50, 32'd9, 32'd0, 32'd0, 1'b1, 1'b0, win);
        launch_phase(0);
        m_rsp_valid = 1'b1; m_rsp_wdat = 32'd5; flush_pulse = 1'b1;
        step();
        m_rsp_valid = 1'b0; flush_pulse = 1'b0;
        #1;
        chk("flush_wait_hit_busy", busy, 1'b0);
        chk("flush_wait_hit_rsp", {r1_rsp_valid, r0_rsp_valid}, 2'b00);

        // A stray unit result in IDLE is not accepted.
        m_rsp_valid = 1'b1;
        #1;
        chk("stray_m_rsp_ready", m_rsp_ready, 1'b0);
        step();
        m_rsp_valid = 1'b0;
        #1;
        chk("stray_busy", busy, 1'b0);
        chk("stray_rsp", {r1_rsp_valid, r0_rsp_valid}, 2'b00);

        // Reset in WAIT: back to reset values, later result ignored, r0 wins next.
        accept_phase(1'b0, 1'b1, 3'd0, 3'd0, 32'd0, 32'd0, 32'd8, 32'd8, 1'b0, 1'b0, win);
        launch_phase(0);
        rst = 1'b1;
        step();
        rst = 1'b0; last_win = 1;
        #1;
        chk("midrst_busy", busy, 1'b0);
        m_rsp_valid = 1'b1; m_rsp_wdat = 32'd64;
        #1;
        chk("midrst_m_rsp_ready", m_rsp_ready, 1'b0);
        step();
        m_rsp_valid = 1'b0;
        #1;
        chk("midrst_rsp", {r1_rsp_valid, r0_rsp_valid}, 2'b00);
        run_txn(1'b1, 1'b1, 3'd3, 3'd7, 32'hDEAD_BEEF, 32'h1234_5678, 32'd77, 32'd0,
                1'b1, 1'b0, 0, 1, 0);

`ifdef E203_MULDIV_ARB_WDT_EN
        // Watchdog: the unit never answers; timeout response, then late result swallowed.
        accept_phase(1'b1, 1'b0, 3'd4, 3'd0, 32'd9, 32'd3, 32'd0, 32'd0, 1'b1, 1'b0, win);
        launch_phase(0);
        for (int i = 1; i <= 64; i++) begin
            chk("wdt_quiet", {r1_rsp_valid, r0_rsp_valid}, 2'b00);
            step();
        end
        resp_phase(0, 0, 32'd0, 1'b1, 1'b1);
        m_rsp_valid = 1'b1; m_rsp_wdat = 32'd3;
        #1;
        chk("wdt_late_ready", m_rsp_ready, 1'b1);
        step();
        m_rsp_valid = 1'b0;
        #1;
        chk("wdt_late_busy", busy, 1'b0);
        chk("wdt_late_rsp", {r1_rsp_valid, r0_rsp_valid}, 2'b00);
`endif

        // Randomized transactions against the model.
        for (int i = 0; i < 40; i++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            if (!v0 && !v1) v0 = 1'b1;
            run_txn(v0, v1, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    $urandom, 32'($urandom_range(0, 3)) == 32'd0 ? 32'd0 : $urandom,
                    $urandom, $urandom,
                    1'($urandom), 1'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
